// File: rtl/multi_filter_classifier_pkg.sv
// Shared constants, state encoding and score helpers for the capture-and-classify controller.
package multi_filter_classifier_pkg;

    localparam int unsigned NUM_STATES = 6;
    typedef logic [NUM_STATES-1:0] state_t;

    // One-hot state encoding
    localparam state_t S_IDLE    = 6'b000001;
    localparam state_t S_CAPTURE = 6'b000010;
    localparam state_t S_DUMP    = 6'b000100;
    localparam state_t S_FILTER  = 6'b001000;
    localparam state_t S_DRAIN   = 6'b010000;
    localparam state_t S_REPORT  = 6'b100000;

    localparam int unsigned REPLAY_GAP  = 3;
    localparam int unsigned RAM_LATENCY = 2;

    // Widest score the helper handles; narrower scores are sign-extended into it.
    localparam int unsigned SCORE_CALC_W = 64;

    function automatic logic signed [SCORE_CALC_W-1:0] signed_max(
        input logic signed [SCORE_CALC_W-1:0] a,
        input logic signed [SCORE_CALC_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/multi_filter_classifier_ram.sv
// Simple dual-port, single-clock RAM: port A writes, port B reads.
// HIGH_PERFORMANCE adds an output register (2-cycle read latency).
module dual_port_ram_1clk #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned DEPTH           = 1024,
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    always_ff @(posedge clk) begin
        if (wea) begin
            mem[addra] <= dina;
        end
    end

    always_ff @(posedge clk) begin
        ram_q <= mem[addrb];
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
            assign doutb = ram_q;
        end else begin : g_high_performance
            always_ff @(posedge clk) begin
                if (rst) begin
                    doutb <= '0;
                end else begin
                    doutb <= ram_q;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/multi_filter_classifier_tracker.sv
// Per-filter peak score register with a saturating count of accepted scores.
module score_peak_tracker
    import multi_filter_classifier_pkg::*;
#(
    parameter int unsigned SCORE_WIDTH = 32,
    parameter int unsigned PASSES      = 2000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic                          clear,
    input  logic signed [SCORE_WIDTH-1:0] score,
    output logic signed [SCORE_WIDTH-1:0] peak,
    output logic                          done
);

    localparam int unsigned CNT_W = $clog2(PASSES + 1);
    localparam logic signed [SCORE_WIDTH-1:0] MOST_NEG = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            peak  <= MOST_NEG;
            count <= '0;
        end else if (valid) begin
            peak <= SCORE_WIDTH'(signed_max(score, peak));
            if (count != CNT_W'(PASSES)) begin
                count <= count + 1'b1;
            end
        end
    end

    assign done = (count == CNT_W'(PASSES));

endmodule

// File: rtl/multi_filter_classifier.sv
// Capture-and-classify controller: captures a burst, optionally dumps it to UART,
// replays it into a matched-filter bank and reports the filter with the highest peak.
module multi_filter_classifier
    import multi_filter_classifier_pkg::*;
#(
    parameter int unsigned SAMPLE_DATA_WIDTH = 8,
    parameter int unsigned CAPTURE_LENGTH    = 1000,
    parameter int unsigned NUM_FILTERS       = 2,
    parameter int unsigned MATCH_SCORE_WIDTH = 32,
    parameter int unsigned PASSES            = 2000,
    localparam int unsigned INDEX_WIDTH      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   trigger,
    input  logic                                   dump_en,
    input  logic                                   axiiv,
    input  logic [SAMPLE_DATA_WIDTH-1:0]           axiid,
    output logic                                   uart_axiiv,
    output logic [7:0]                             uart_axiid,
    input  logic                                   uart_axiready,
    output logic                                   filt_axiiv,
    output logic [SAMPLE_DATA_WIDTH-1:0]           filt_axiid,
    input  logic [NUM_FILTERS-1:0]                 filt_axiov,
    input  logic [NUM_FILTERS*MATCH_SCORE_WIDTH-1:0] filt_axiod,
    output logic                                   result_valid,
    input  logic                                   result_ready,
    output logic [INDEX_WIDTH-1:0]                 result_index,
    output logic [MATCH_SCORE_WIDTH-1:0]           result_score,
    output logic                                   busy
);

    localparam int unsigned ADDR_W = $clog2(CAPTURE_LENGTH);
    localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int unsigned GAP_W  = $clog2(REPLAY_GAP + 1);
    localparam int unsigned WAIT_W = $clog2(RAM_LATENCY + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CAPTURE_LENGTH - 1);

    state_t                  state;
    logic                    dump_sel;
    logic [ADDR_W-1:0]       wr_addr;
    logic [ADDR_W-1:0]       rd_addr;
    logic [PASS_W-1:0]       pass_cnt;
    logic                    in_gap;
    logic [GAP_W-1:0]        gap_cnt;
    logic [WAIT_W-1:0]       wait_cnt;
    logic                    rd_en;
    logic                    rd_en_q;
    logic                    ram_we;
    logic [SAMPLE_DATA_WIDTH-1:0] ram_dout;
    logic                    accept;
    logic                    release_result;

    logic signed [MATCH_SCORE_WIDTH-1:0] peaks [NUM_FILTERS];
    logic [NUM_FILTERS-1:0]              done;
    logic [INDEX_WIDTH-1:0]              best_index;
    logic signed [MATCH_SCORE_WIDTH-1:0] best_score;

    assign ram_we         = (state == S_CAPTURE) && axiiv;
    assign rd_en          = (state == S_FILTER) && !in_gap;
    assign accept         = (state == S_FILTER) || (state == S_DRAIN);
    assign release_result = (state == S_REPORT) && result_valid && result_ready;
    assign busy           = (state != S_IDLE);
    assign filt_axiid     = ram_dout;

    dual_port_ram_1clk #(
        .DATA_WIDTH      (SAMPLE_DATA_WIDTH),
        .DEPTH           (CAPTURE_LENGTH),
        .ADDR_WIDTH      (ADDR_W),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_capture_ram (
        .clk   (clk),
        .rst   (rst),
        .wea   (ram_we),
        .addra (wr_addr),
        .dina  (axiid),
        .addrb (rd_addr),
        .doutb (ram_dout)
    );

    generate
        for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_tracker
            score_peak_tracker #(
                .SCORE_WIDTH (MATCH_SCORE_WIDTH),
                .PASSES      (PASSES)
            ) u_tracker (
                .clk   (clk),
                .rst   (rst),
                .valid (accept && filt_axiov[i]),
                .clear (release_result),
                .score (filt_axiod[i*MATCH_SCORE_WIDTH +: MATCH_SCORE_WIDTH]),
                .peak  (peaks[i]),
                .done  (done[i])
            );
        end
    endgenerate

    // Strictly-greater scan so the lowest index wins ties.
    always_comb begin
        best_index = '0;
        best_score = peaks[0];
        for (int unsigned i = 1; i < NUM_FILTERS; i++) begin
            if (peaks[i] > best_score) begin
                best_score = peaks[i];
                best_index = INDEX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            dump_sel     <= 1'b0;
            wr_addr      <= '0;
            rd_addr      <= '0;
            pass_cnt     <= '0;
            in_gap       <= 1'b0;
            gap_cnt      <= '0;
            wait_cnt     <= '0;
            rd_en_q      <= 1'b0;
            filt_axiiv   <= 1'b0;
            uart_axiiv   <= 1'b0;
            uart_axiid   <= '0;
            result_valid <= 1'b0;
            result_index <= '0;
            result_score <= '0;
        end else begin
            // Valid follows the read address through the two RAM register stages.
            rd_en_q    <= rd_en;
            filt_axiiv <= rd_en_q;
            uart_axiiv <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        dump_sel <= dump_en;
                        wr_addr  <= '0;
                        state    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (axiiv) begin
                        wr_addr <= wr_addr + 1'b1;
                        if (wr_addr == LAST_ADDR) begin
                            rd_addr  <= '0;
                            wait_cnt <= '0;
                            pass_cnt <= '0;
                            in_gap   <= 1'b0;
                            gap_cnt  <= '0;
                            state    <= dump_sel ? S_DUMP : S_FILTER;
                        end
                    end
                end
                S_DUMP: begin
                    if (wait_cnt != WAIT_W'(RAM_LATENCY)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else if (uart_axiready && !uart_axiiv) begin
                        uart_axiiv <= 1'b1;
                        uart_axiid <= 8'(ram_dout);
                        wait_cnt   <= '0;
                        if (rd_addr == LAST_ADDR) begin
                            rd_addr <= '0;
                            state   <= S_FILTER;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                S_FILTER: begin
                    if (!in_gap) begin
                        if (rd_addr == LAST_ADDR) begin
                            in_gap  <= 1'b1;
                            gap_cnt <= '0;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                        if (gap_cnt == GAP_W'(REPLAY_GAP - 1)) begin
                            in_gap  <= 1'b0;
                            rd_addr <= '0;
                            if (pass_cnt == PASS_W'(PASSES - 1)) begin
                                state <= S_DRAIN;
                            end else begin
                                pass_cnt <= pass_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (&done) begin
                        result_index <= best_index;
                        result_score <= best_score;
                        result_valid <= 1'b1;
                        state        <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
